// File: rtl/ctrl_gen_pkg.sv
// Shared opcode constants, state encoding and helpers for the ctrl_gen host command controller.
package ctrl_gen_pkg;

  localparam logic [2:0] OUT_DATA1 = 3'd0;
  localparam logic [2:0] OUT_DATA2 = 3'd1;
  localparam logic [2:0] OUT_RES   = 3'd2;
  localparam logic [2:0] OUT_CFG   = 3'd3;
  localparam logic [2:0] OUT_START = 3'd4;
  localparam logic [2:0] OUT_STOP  = 3'd5;
  localparam logic [2:0] OUT_SYNC  = 3'd6;
  localparam logic [2:0] NO_OP     = 3'd7;

  localparam logic [7:0] BCAST_ADDR = 8'hFF;

  typedef enum logic [7:0] {
    S_IDLE     = 8'd0,
    S_OPCODE   = 8'd1,
    S_DECODE   = 8'd2,
    S_DATA     = 8'd3,
    S_CHECK    = 8'd4,
    S_STALL    = 8'd5,
    S_ACC      = 8'd6,
    S_SEND     = 8'd7,
    S_SEND_GAP = 8'd8,
    S_DONE     = 8'd9
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic is_data_op(input logic [2:0] opc);
    return (opc == OUT_DATA1) || (opc == OUT_DATA2);
  endfunction

endpackage

// File: rtl/ctrl_gen_timer.sv
// Loadable down-counter shared by the stall, accumulate, inter-byte timeout and TX busy-wait phases.
module ctrl_gen_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr_en,
  input  logic         in,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load || (clr_en && in)) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/ctrl_gen.sv
// Host command controller: parses UART frames (address, opcode, payload) and sequences array send/acc/readback.
// Optional trailing XOR checksum byte per frame is enabled by defining CTRL_CHECKSUM_EN.
module ctrl_gen
  import ctrl_gen_pkg::*;
#(
  parameter logic [7:0]  NODE_ADDR    = 8'h00,
  parameter int unsigned DATA_BYTES   = 4,
  parameter int unsigned RES_BYTES    = 16,
  parameter int unsigned STALL_CYCLES = 16,
  parameter int unsigned ACC_CYCLES   = 128,
  parameter int unsigned TIMEOUT      = 1024,
  localparam int unsigned SEL_W       = $clog2(RES_BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             in,
  input  logic             busy,
  output logic             get,
  output logic [7:0]       status,
  output logic [2:0]       op,
  output logic [SEL_W-1:0] sel,
  output logic             acc,
  output logic             clear,
  output logic             out,
  output logic             send,
  output logic             err,
  output logic             addr_hit
);

  localparam int unsigned TMAX  = max3(STALL_CYCLES, ACC_CYCLES, TIMEOUT);
  localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             addr_hit_q, addr_hit_d;
  logic             err_q, err_d;
  logic             acc_q, acc_d;
  logic             clear_q, clear_d;
  logic             out_q, out_d;
  logic             send_q, send_d;
`ifdef CTRL_CHECKSUM_EN
  logic [7:0]       xsum_q, xsum_d;
`endif

  logic          exec_ctrl;
  logic          t_load, t_clr_en, t_expired;
  logic [TW-1:0] t_val;

  ctrl_gen_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .clr_en   (t_clr_en),
    .in       (in),
    .load_val (t_val),
    .expired  (t_expired)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    addr_hit_d = addr_hit_q;
    err_d      = err_q;
    clear_d    = 1'b0;
    out_d      = 1'b0;
    send_d     = 1'b0;
`ifdef CTRL_CHECKSUM_EN
    xsum_d     = xsum_q;
`endif
    exec_ctrl  = 1'b0;
    t_load     = 1'b0;
    t_clr_en   = 1'b0;
    t_val      = TW'(TIMEOUT - 1);

    unique case (state_q)
      S_IDLE: begin
        t_clr_en = 1'b1;
        if (in) begin
          addr_hit_d = (data_in == NODE_ADDR) || (data_in == BCAST_ADDR);
          state_d    = S_OPCODE;
`ifdef CTRL_CHECKSUM_EN
          xsum_d     = data_in;
`endif
        end
      end

      S_OPCODE: begin
        t_clr_en = 1'b1;
        if (in) begin
          if (data_in[7:3] != '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            op_d    = data_in[2:0];
            state_d = S_DECODE;
`ifdef CTRL_CHECKSUM_EN
            xsum_d  = xsum_q ^ data_in;
`endif
          end
        end else if (t_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_DECODE: begin
        if (is_data_op(op_q)) begin
          cnt_d   = '0;
          t_load  = 1'b1;
          state_d = S_DATA;
        end else begin
`ifdef CTRL_CHECKSUM_EN
          t_load  = 1'b1;
          state_d = S_CHECK;
`else
          exec_ctrl = 1'b1;
`endif
        end
      end

      S_DATA: begin
        t_clr_en = 1'b1;
        if (in) begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef CTRL_CHECKSUM_EN
          xsum_d = xsum_q ^ data_in;
`endif
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
`ifdef CTRL_CHECKSUM_EN
            state_d = S_CHECK;
`else
            send_d  = addr_hit_q;
            state_d = S_IDLE;
`endif
          end
        end else if (t_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

`ifdef CTRL_CHECKSUM_EN
      S_CHECK: begin
        t_clr_en = 1'b1;
        if (in) begin
          if (data_in != xsum_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (is_data_op(op_q)) begin
            send_d  = addr_hit_q;
            state_d = S_IDLE;
          end else begin
            exec_ctrl = 1'b1;
          end
        end else if (t_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif

      S_STALL: begin
        if (t_expired) begin
          send_d  = 1'b1;
          t_load  = 1'b1;
          t_val   = TW'(ACC_CYCLES - 1);
          state_d = S_ACC;
        end
      end

      S_ACC: begin
        if (t_expired) begin
          sel_d   = '0;
          t_load  = 1'b1;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (!busy) begin
          out_d   = 1'b1;
          state_d = S_SEND_GAP;
        end else if (t_expired) begin
          err_d   = 1'b1;
          clear_d = 1'b1;
          sel_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_SEND_GAP: begin
        if (sel_q == SEL_W'(RES_BYTES - 1)) begin
          state_d = S_DONE;
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          t_load  = 1'b1;
          state_d = S_SEND;
        end
      end

      S_DONE: begin
        clear_d = 1'b1;
        sel_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Control-op dispatch is shared by DECODE (plain frames) and CHECK (checksummed frames).
    if (exec_ctrl) begin
      state_d = S_IDLE;
      if (op_q == OUT_RES) begin
        if (addr_hit_q) begin
          t_load  = 1'b1;
          t_val   = TW'(STALL_CYCLES - 1);
          state_d = S_STALL;
        end
      end else begin
        send_d = addr_hit_q;
        if ((op_q == NO_OP) && addr_hit_q) begin
          err_d = 1'b0;
        end
      end
    end

    acc_d = (state_d == S_ACC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      addr_hit_q <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= 1'b0;
      clear_q    <= 1'b0;
      out_q      <= 1'b0;
      send_q     <= 1'b0;
`ifdef CTRL_CHECKSUM_EN
      xsum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      addr_hit_q <= addr_hit_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      clear_q    <= clear_d;
      out_q      <= out_d;
      send_q     <= send_d;
`ifdef CTRL_CHECKSUM_EN
      xsum_q     <= xsum_d;
`endif
    end
  end

  assign get      = in;
  assign status   = state_q;
  assign op       = op_q;
  assign sel      = sel_q;
  assign acc      = acc_q;
  assign clear    = clear_q;
  assign out      = out_q;
  assign send     = send_q;
  assign err      = err_q;
  assign addr_hit = addr_hit_q;

endmodule

// File: tb/tb_ctrl_gen.sv
// Self-checking bench for ctrl_gen: table of frames with a scoreboard queue, plus readback/timeout/reset sequences.
module tb_ctrl_gen;

  localparam logic [7:0]  NODE         = 8'h03;
  localparam int unsigned DATA_BYTES   = 4;
  localparam int unsigned RES_BYTES    = 16;
  localparam int unsigned STALL_CYCLES = 16;
  localparam int unsigned ACC_CYCLES   = 128;
  localparam int unsigned TIMEOUT      = 1024;
  localparam int unsigned SEL_W        = $clog2(RES_BYTES);
`ifdef CTRL_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       data_in = '0;
  logic             in = 1'b0;
  logic             busy;
  logic             get;
  logic [7:0]       status;
  logic [2:0]       op;
  logic [SEL_W-1:0] sel;
  logic             acc, clear, out, send, err, addr_hit;

  always #5 clk = ~clk;

  ctrl_gen #(
    .NODE_ADDR    (NODE),
    .DATA_BYTES   (DATA_BYTES),
    .RES_BYTES    (RES_BYTES),
    .STALL_CYCLES (STALL_CYCLES),
    .ACC_CYCLES   (ACC_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .in       (in),
    .busy     (busy),
    .get      (get),
    .status   (status),
    .op       (op),
    .sel      (sel),
    .acc      (acc),
    .clear    (clear),
    .out      (out),
    .send     (send),
    .err      (err),
    .addr_hit (addr_hit)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // UART TX model: busy rises with each out strobe and drops two cycles later.
  logic busy_model = 1'b0;
  logic busy_stuck = 1'b0;
  int   bcnt       = 0;
  assign busy = busy_model | busy_stuck;

  int send_cnt = 0, out_cnt = 0, clear_cnt = 0, excl_viol = 0;
  int sel_exp_q[$];

  always @(negedge clk) begin
    if (send)  send_cnt++;
    if (clear) clear_cnt++;
    if (int'(send) + int'(out) + int'(clear) > 1) excl_viol++;
    if (out) begin
      out_cnt++;
      check("out_expected", int'(sel_exp_q.size() > 0), 1);
      if (sel_exp_q.size() > 0) check("out_sel", int'(sel), sel_exp_q.pop_front());
      busy_model = 1'b1;
      bcnt = 2;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) busy_model = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    in = 1'b1;
    #1 check("get_echo", int'(get), 1);
    @(negedge clk);
    in = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] by, input int n, input bit ck, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    for (int i = 0; i < n; i++) begin
      b = by[63-8*i -: 8];
      x ^= b;
      send_byte(b);
    end
    if (CK_EN && ck) send_byte(corrupt ? ~x : x);
  endtask

  typedef struct {
    string       name;
    logic [63:0] by;
    int          n;
    bit          ck;
    int          exp_send;
    int          exp_hit;
    int          exp_err;
    int          exp_op;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [63:0] by, input int n, input bit ck,
                              input int s, input int h, input int e, input int o);
    vec_t v;
    v.name = nm; v.by = by; v.n = n; v.ck = ck;
    v.exp_send = s; v.exp_hit = h; v.exp_err = e; v.exp_op = o;
    return v;
  endfunction

  vec_t vt[8];
  vec_t exp_q[$];

  initial begin
    vec_t e;
    int   base_s, base_o, base_c, n, a;
    bit   imm;

    vt[0] = mk("data1_own",   64'h03_00_11_22_33_44_00_00, 6, 1, 1, 1, 0, 0);
    vt[1] = mk("data1_other", 64'h05_00_AA_BB_CC_DD_00_00, 6, 1, 0, 0, 0, 0);
    vt[2] = mk("bcast_cfg",   64'hFF_03_00_00_00_00_00_00, 2, 1, 1, 1, 0, 3);
    vt[3] = mk("data2_own",   64'h03_01_01_02_03_04_00_00, 6, 1, 1, 1, 0, 1);
    vt[4] = mk("stop_other",  64'h07_05_00_00_00_00_00_00, 2, 1, 0, 0, 0, 5);
    vt[5] = mk("bad_opcode",  64'h03_09_00_00_00_00_00_00, 2, 0, 0, 1, 1, 5);
    vt[6] = mk("noop_other",  64'h05_07_00_00_00_00_00_00, 2, 1, 0, 0, 1, 7);
    vt[7] = mk("noop_own",    64'h03_07_00_00_00_00_00_00, 2, 1, 1, 1, 0, 7);

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_status", int'(status), 0);
    check("rst_op", int'(op), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_send", int'(send), 0);
    check("rst_err", int'(err), 0);
    check("rst_hit", int'(addr_hit), 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame table with scoreboard
    for (int i = 0; i < 8; i++) begin
      base_s = send_cnt;
      exp_q.push_back(vt[i]);
      send_frame(vt[i].by, vt[i].n, vt[i].ck, 1'b0);
      imm = (vt[i].exp_send != 0) && ((vt[i].exp_op <= 1) || CK_EN);
      check({vt[i].name, "_send_lat"}, int'(send), int'(imm));
      repeat (4) @(negedge clk);
      e = exp_q.pop_front();
      check({e.name, "_sends"}, send_cnt - base_s, e.exp_send);
      check({e.name, "_hit"}, int'(addr_hit), e.exp_hit);
      check({e.name, "_err"}, int'(err), e.exp_err);
      check({e.name, "_op"}, int'(op), e.exp_op);
      check({e.name, "_idle"}, int'(status), 0);
    end

    // Broadcast readback: stall, accumulate window, 16 TX bytes, clear
    base_s = send_cnt; base_o = out_cnt; base_c = clear_cnt;
    for (int k = 0; k < int'(RES_BYTES); k++) sel_exp_q.push_back(k);
    send_frame(64'hFF_02_00_00_00_00_00_00, 2, 1'b1, 1'b0);
    n = 0;
    while (!send && n < 200) begin @(negedge clk); n++; end
    check("stall_len", n, CK_EN ? int'(STALL_CYCLES) : int'(STALL_CYCLES) + 1);
    a = 0;
    while (acc && a < 1000) begin a++; @(negedge clk); end
    check("acc_len", a, int'(ACC_CYCLES));
    n = 0;
    while (status != 8'd0 && n < 3000) begin @(negedge clk); n++; end
    check("rb_idle", int'(status), 0);
    repeat (2) @(negedge clk);
    check("rb_sends", send_cnt - base_s, 1);
    check("rb_outs", out_cnt - base_o, int'(RES_BYTES));
    check("rb_clear", clear_cnt - base_c, 1);
    check("rb_sel_left", sel_exp_q.size(), 0);
    check("rb_sel0", int'(sel), 0);
    check("rb_err", int'(err), 0);

    // Inter-byte timeout inside a payload
    base_s = send_cnt;
    send_frame(64'h03_01_11_00_00_00_00_00, 3, 1'b0, 1'b0);
    repeat (TIMEOUT - 2) @(negedge clk);
    check("pre_to_err", int'(err), 0);
    check("pre_to_busy", int'(status != 8'd0), 1);
    repeat (4) @(negedge clk);
    check("to_err", int'(err), 1);
    check("to_idle", int'(status), 0);
    check("to_nosend", send_cnt - base_s, 0);
    send_frame(64'h03_07_00_00_00_00_00_00, 2, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("noop_clr_err", int'(err), 0);

    // TX busy stuck high: busy-wait timeout
    busy_stuck = 1'b1;
    base_o = out_cnt; base_c = clear_cnt;
    send_frame(64'hFF_02_00_00_00_00_00_00, 2, 1'b1, 1'b0);
    n = 0;
    while (status != 8'd0 && n < 3000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("bto_idle", int'(status), 0);
    check("bto_err", int'(err), 1);
    check("bto_outs", out_cnt - base_o, 0);
    check("bto_clear", clear_cnt - base_c, 1);
    busy_stuck = 1'b0;
    send_frame(64'h03_07_00_00_00_00_00_00, 2, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("bto_noop_clr", int'(err), 0);

`ifdef CTRL_CHECKSUM_EN
    base_s = send_cnt;
    send_frame(64'h03_00_01_02_03_04_07_00, 7, 1'b0, 1'b0);
    check("ck_good_send", int'(send), 1);
    check("ck_good_err", int'(err), 0);
    repeat (3) @(negedge clk);
    base_s = send_cnt;
    send_frame(64'h03_00_01_02_03_04_06_00, 7, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("ck_bad_err", int'(err), 1);
    check("ck_bad_nosend", send_cnt - base_s, 0);
    send_frame(64'h03_07_00_00_00_00_00_00, 2, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("ck_noop_clr", int'(err), 0);
`endif

    // Synchronous reset in the middle of readback
    for (int k = 0; k < int'(RES_BYTES); k++) sel_exp_q.push_back(k);
    send_frame(64'hFF_02_00_00_00_00_00_00, 2, 1'b1, 1'b0);
    n = 0;
    while (!(out && sel == SEL_W'(7)) && n < 3000) begin @(negedge clk); n++; end
    check("mid_reach_sel7", int'(sel), 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_status", int'(status), 0);
    check("mrst_op", int'(op), 0);
    check("mrst_sel", int'(sel), 0);
    check("mrst_acc", int'(acc), 0);
    check("mrst_clear", int'(clear), 0);
    check("mrst_out", int'(out), 0);
    check("mrst_send", int'(send), 0);
    check("mrst_err", int'(err), 0);
    check("mrst_hit", int'(addr_hit), 0);
    @(negedge clk);
    rst = 1'b0;
    sel_exp_q.delete();
    repeat (4) @(negedge clk);

    check("exclusive_strobes", excl_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
